// File: rtl/spi_frame_loader_if.sv
// Word, framebuffer-write, swap-handshake and status signals between the SPI side and the
// frame loader. master drives received words and swap_ack; slave is the loader.
interface spi_frame_loader_if #(
  parameter int unsigned ADDR_W = 11
);
  logic              word_valid;
  logic [31:0]       word_data;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [23:0]       fb_data;
  logic              fb_buf;
  logic              swap_req;
  logic              swap_ack;
  logic [7:0]        brightness;
  logic              busy;
  logic [7:0]        err_count;

  modport master (
    output word_valid,
    output word_data,
    output swap_ack,
    input  fb_we,
    input  fb_addr,
    input  fb_data,
    input  fb_buf,
    input  swap_req,
    input  brightness,
    input  busy,
    input  err_count
  );

  modport slave (
    input  word_valid,
    input  word_data,
    input  swap_ack,
    output fb_we,
    output fb_addr,
    output fb_data,
    output fb_buf,
    output swap_req,
    output brightness,
    output busy,
    output err_count
  );
endinterface

// File: rtl/spi_frame_loader.sv
// Decodes SPI words into header commands and back-buffer pixel writes, and runs the
// buffer-swap handshake with the scan side.
module spi_frame_loader #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned HEIGHT = 32,
  parameter int unsigned ADDR_W = 11
) (
  input  logic                spi_clk,
  input  logic                reset,
  spi_frame_loader_if.slave   bus
);

  localparam int unsigned Pixels = WIDTH * HEIGHT;
  localparam int unsigned CntW   = $clog2(Pixels + 1);

  localparam logic [7:0] SyncByte      = 8'hA5;
  localparam logic [7:0] CmdStartFrame = 8'h01;
  localparam logic [7:0] CmdStartRow   = 8'h02;
  localparam logic [7:0] CmdSwap       = 8'h03;
  localparam logic [7:0] CmdBrightness = 8'h04;

  typedef enum logic [1:0] {StIdle, StStream, StSwapWait} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CntW-1:0]   remain_q, remain_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [23:0]       fb_data_q, fb_data_d;
  logic              fb_buf_q, fb_buf_d;
  logic              swap_req_q, swap_req_d;
  logic [7:0]        bright_q, bright_d;
  logic [7:0]        err_q, err_d;
  logic              err_inc;

  logic [7:0]  hdr_sync;
  logic [7:0]  hdr_cmd;
  logic [15:0] hdr_arg;

  assign hdr_sync = bus.word_data[31:24];
  assign hdr_cmd  = bus.word_data[23:16];
  assign hdr_arg  = bus.word_data[15:0];

  // State register
  always_ff @(posedge spi_clk) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      remain_q   <= '0;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      fb_buf_q   <= 1'b1;
      swap_req_q <= 1'b0;
      bright_q   <= 8'hFF;
      err_q      <= 8'h00;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      fb_buf_q   <= fb_buf_d;
      swap_req_q <= swap_req_d;
      bright_q   <= bright_d;
      err_q      <= err_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    fb_buf_d   = fb_buf_q;
    swap_req_d = swap_req_q;
    bright_d   = bright_q;
    err_inc    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.word_valid) begin
          if (hdr_sync != SyncByte) begin
            err_inc = 1'b1;
          end else begin
            case (hdr_cmd)
              CmdStartFrame: begin
                addr_d   = '0;
                remain_d = CntW'(Pixels);
                state_d  = StStream;
              end
              CmdStartRow: begin
                if (32'(hdr_arg) < HEIGHT) begin
                  addr_d   = ADDR_W'(32'(hdr_arg) * WIDTH);
                  remain_d = CntW'(WIDTH);
                  state_d  = StStream;
                end else begin
                  err_inc = 1'b1;
                end
              end
              CmdSwap: begin
                swap_req_d = 1'b1;
                state_d    = StSwapWait;
              end
              CmdBrightness: bright_d = hdr_arg[7:0];
              default:       err_inc  = 1'b1;
            endcase
          end
        end
      end

      StStream: begin
        // Every word is a pixel here, even one that looks like a header.
        if (bus.word_valid) begin
          fb_we_d   = 1'b1;
          fb_addr_d = addr_q;
          fb_data_d = bus.word_data[23:0];
          addr_d    = addr_q + ADDR_W'(1);
          remain_d  = remain_q - CntW'(1);
          if (remain_q == CntW'(1)) begin
            state_d = StIdle;
          end
        end
      end

      StSwapWait: begin
        if (bus.word_valid) begin
          err_inc = 1'b1;
        end
        if (bus.swap_ack) begin
          swap_req_d = 1'b0;
          fb_buf_d   = ~fb_buf_q;
          state_d    = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    err_d = (err_inc && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  // Outputs
  always_comb begin
    bus.busy       = (state_q != StIdle);
    bus.fb_we      = fb_we_q;
    bus.fb_addr    = fb_addr_q;
    bus.fb_data    = fb_data_q;
    bus.fb_buf     = fb_buf_q;
    bus.swap_req   = swap_req_q;
    bus.brightness = bright_q;
    bus.err_count  = err_q;
  end

endmodule

// File: tb/tb_spi_frame_loader.sv
// Randomized scoreboard bench for spi_frame_loader against a behavioural model of the loader.
module tb_spi_frame_loader;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned HEIGHT = 32;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned PIXELS = WIDTH * HEIGHT;

  logic spi_clk = 1'b0;
  logic reset   = 1'b1;

  spi_frame_loader_if #(.ADDR_W(ADDR_W)) bus ();

  spi_frame_loader #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ADDR_W(ADDR_W)
  ) dut (
    .spi_clk(spi_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 spi_clk = ~spi_clk;

  typedef struct {
    int unsigned addr;
    int unsigned data;
    bit          buf_idx;
    int          cyc;
  } wr_t;

  typedef enum int {MIdle, MStream, MSwap} mode_e;

  wr_t   exp_q[$];
  int    checks  = 0;
  int    errors  = 0;
  int    cyc     = 0;
  int    req_cnt = 0;
  bit    mon_en  = 1'b0;

  // Predicted state after the inputs currently driven are sampled, and the copy valid now.
  mode_e       p_mode, c_mode;
  int unsigned p_addr, p_left, p_bright, p_err, c_bright, c_err;
  bit          p_buf, c_buf;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    p_mode   = MIdle;
    p_addr   = 0;
    p_left   = 0;
    p_bright = 255;
    p_err    = 0;
    p_buf    = 1'b1;
  endfunction

  function automatic void bump_err();
    if (p_err < 255) p_err++;
  endfunction

  function automatic void model_step(bit v, logic [31:0] w, bit a);
    wr_t e;
    case (p_mode)
      MIdle: if (v) begin
        if (w[31:24] != 8'hA5) bump_err();
        else if (w[23:16] == 8'h01) begin
          p_addr = 0; p_left = PIXELS; p_mode = MStream;
        end else if (w[23:16] == 8'h02) begin
          if (w[15:0] < HEIGHT) begin
            p_addr = w[15:0] * WIDTH; p_left = WIDTH; p_mode = MStream;
          end else bump_err();
        end else if (w[23:16] == 8'h03) p_mode = MSwap;
        else if (w[23:16] == 8'h04) p_bright = w[7:0];
        else bump_err();
      end
      MStream: if (v) begin
        e.addr = p_addr; e.data = w[23:0]; e.buf_idx = p_buf; e.cyc = cyc + 1;
        exp_q.push_back(e);
        p_addr++;
        p_left--;
        if (p_left == 0) p_mode = MIdle;
      end
      default: begin
        if (v) bump_err();
        if (a) begin
          p_buf  = ~p_buf;
          p_mode = MIdle;
        end
      end
    endcase
  endfunction

  always @(posedge spi_clk) begin
    cyc      <= cyc + 1;
    c_mode   <= p_mode;
    c_bright <= p_bright;
    c_err    <= p_err;
    c_buf    <= p_buf;
  end

  // Monitor: pops expected writes on fb_we and compares status outputs every cycle.
  always @(negedge spi_clk) begin : mon
    wr_t e;
    if (mon_en) begin
      if (bus.fb_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_fb_we", 32'(bus.fb_we), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("fb_we_latency", cyc, e.cyc);
          chk("fb_addr", 32'(bus.fb_addr), e.addr);
          chk("fb_data", 32'(bus.fb_data), e.data);
          chk("fb_buf_on_write", 32'(bus.fb_buf), 32'(e.buf_idx));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("missed_fb_we", 32'(bus.fb_we), 32'd1);
      end
      chk("swap_req", 32'(bus.swap_req), 32'(c_mode == MSwap));
      chk("busy", 32'(bus.busy), 32'(c_mode != MIdle));
      chk("fb_buf", 32'(bus.fb_buf), 32'(c_buf));
      chk("brightness", 32'(bus.brightness), c_bright);
      chk("err_count", 32'(bus.err_count), c_err);
      if (bus.swap_req) req_cnt <= req_cnt + 1;
    end
  end

  task automatic tick(bit v, logic [31:0] w, bit a);
    @(posedge spi_clk);
    #1;
    bus.word_valid = v;
    bus.word_data  = w;
    bus.swap_ack   = a;
    model_step(v, w, a);
  endtask

  task automatic settle();
    tick(1'b0, 32'h0, 1'b0);
    @(negedge spi_clk);
  endtask

  task automatic do_reset(int n);
    @(posedge spi_clk);
    #1;
    reset          = 1'b1;
    bus.word_valid = 1'b0;
    bus.swap_ack   = 1'b0;
    model_reset();
    repeat (n) @(posedge spi_clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic send_pixels(int n, bit gaps, bit idx_data);
    logic [31:0] w;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      if (idx_data) w[23:0] = 24'(i);
      tick(1'b1, w, 1'b0);
      if (gaps && ($urandom % 4 == 0)) repeat (1 + $urandom % 2) tick(1'b0, 32'h0, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] w;
    bit v, a;
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    bus.swap_ack   = 1'b0;
    model_reset();

    // Reset values
    do_reset(2);
    @(negedge spi_clk);
    chk("rst_fb_we", 32'(bus.fb_we), 32'd0);
    chk("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
    chk("rst_fb_data", 32'(bus.fb_data), 32'd0);
    chk("rst_fb_buf", 32'(bus.fb_buf), 32'd1);
    chk("rst_brightness", 32'(bus.brightness), 32'hFF);

    // Full frame with index data and random gaps
    tick(1'b1, 32'hA501_0000, 1'b0);
    send_pixels(PIXELS, 1'b1, 1'b1);
    settle();
    chk("busy_after_frame", 32'(bus.busy), 32'd0);

    // Row 5, then a header right after the last pixel
    tick(1'b1, 32'hA502_0005, 1'b0);
    send_pixels(WIDTH, 1'b0, 1'b0);
    tick(1'b1, 32'hA504_0080, 1'b0);
    settle();
    chk("row_then_brightness", 32'(bus.brightness), 32'h80);

    // Swap with late ack and two dropped words
    req_cnt = 0;
    tick(1'b1, 32'hA503_0000, 1'b0);
    for (int i = 0; i < 7; i++) tick(i == 1 || i == 4, $urandom, 1'b0);
    tick(1'b0, 32'h0, 1'b1);
    settle();
    chk("swap_req_cycles", req_cnt, 32'd8);
    chk("swap_fb_buf", 32'(bus.fb_buf), 32'd0);
    chk("swap_err_count", 32'(bus.err_count), 32'd2);

    // Immediate ack, then ack together with a word
    tick(1'b1, 32'hA503_0000, 1'b0);
    tick(1'b0, 32'h0, 1'b1);
    tick(1'b1, 32'hA503_0000, 1'b0);
    tick(1'b1, $urandom, 1'b1);
    settle();
    chk("swap2_fb_buf", 32'(bus.fb_buf), 32'd0);
    chk("swap2_err_count", 32'(bus.err_count), 32'd3);

    // Protocol errors and saturation
    do_reset(2);
    tick(1'b1, 32'h1201_0000, 1'b0);
    tick(1'b1, 32'hA502_0020, 1'b0);
    tick(1'b1, 32'hA57F_0000, 1'b0);
    settle();
    chk("err_three", 32'(bus.err_count), 32'd3);
    chk("err_idle", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 300; i++) tick(1'b1, {8'h5A, 24'($urandom)}, 1'b0);
    settle();
    chk("err_saturate", 32'(bus.err_count), 32'd255);

    // Reset at pixel 10 of a frame
    tick(1'b1, 32'hA501_0000, 1'b0);
    send_pixels(10, 1'b0, 1'b1);
    @(posedge spi_clk);
    #1;
    reset          = 1'b1;
    bus.word_valid = 1'b1;
    bus.word_data  = 32'h0000_000A;
    model_reset();
    @(posedge spi_clk);
    #1;
    bus.word_valid = 1'b0;
    @(negedge spi_clk);
    chk("midrst_fb_we", 32'(bus.fb_we), 32'd0);
    chk("midrst_fb_addr", 32'(bus.fb_addr), 32'd0);
    chk("midrst_err", 32'(bus.err_count), 32'd0);
    @(posedge spi_clk);
    #1;
    reset = 1'b0;
    repeat (3) tick(1'b0, 32'h0, 1'b0);

    // Fresh frame, back-to-back words
    tick(1'b1, 32'hA501_0000, 1'b0);
    send_pixels(PIXELS, 1'b0, 1'b0);
    settle();
    chk("b2b_done", 32'(bus.busy), 32'd0);

    // Random traffic
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom % 3) != 0;
      a = ($urandom % 5) == 0;
      w = $urandom;
      if (p_mode == MIdle && ($urandom % 10) < 8) begin
        w[31:24] = (($urandom % 8) == 0) ? 8'h3C : 8'hA5;
        case ($urandom % 12)
          0:            w[23:16] = 8'h01;
          1, 2, 3, 4:   begin w[23:16] = 8'h02; w[15:0] = 16'($urandom % 40); end
          5, 6, 7:      w[23:16] = 8'h03;
          8, 9:         w[23:16] = 8'h04;
          default:      w[23:16] = 8'($urandom % 16);
        endcase
      end
      tick(v, w, a);
    end
    settle();
    settle();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_frame_loader.md
Name: spi_frame_loader

Overview:
- Command/stream sequencer between the SPI word receiver and the dual-buffered panel framebuffer.
- Decodes 32-bit words from the SPI link into header commands and pixel writes.
- Generates framebuffer write address, data and strobe into the back buffer.
- Schedules buffer swaps with the display scan side through a req/ack handshake, and holds panel brightness.

Parameters:
- WIDTH, 64, pixels per row.
- HEIGHT, 32, rows per frame.
- ADDR_W, 11, framebuffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.

Ports:
- spi_clk  in  1  block clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- word_valid  in  1  one-cycle pulse: word_data holds a newly completed 32-bit word.
- word_data  in  32  received word, stable while word_valid=1.
- fb_we  out  1  framebuffer write strobe, one cycle per pixel.
- fb_addr  out  ADDR_W  pixel address, row*WIDTH+col.
- fb_data  out  24  RGB888 pixel, from word_data[23:0].
- fb_buf  out  1  back-buffer index written by fb_we; equals !display buffer.
- swap_req  out  1  buffer swap request to the scan side.
- swap_ack  in  1  scan-side acknowledge, already synchronous to spi_clk.
- brightness  out  8  global brightness register.
- busy  out  1  high in any state other than IDLE.
- err_count  out  8  protocol error counter, saturating at 255.

Behaviour:
- Reset state and values:
  - Synchronous reset forces IDLE.
  - fb_we=0, fb_addr=0, fb_data=0, fb_buf=1, swap_req=0, brightness=0xFF, err_count=0, busy=0.
  - Reset mid-stream or mid-swap abandons the operation; no further fb_we pulses.
- Header word format:
  - [31:24] must be sync byte 0xA5.
  - [23:16] command.
  - [15:0] argument.
- States: IDLE, STREAM, SWAP_WAIT.
- IDLE, on word_valid:
  - Sync byte is not 0xA5 -> err_count+1, stay IDLE.
  - cmd 0x01 START_FRAME -> pixel counter := 0, remaining := WIDTH*HEIGHT, go to STREAM.
  - cmd 0x02 START_ROW, arg[15:0] = row:
    - row < HEIGHT -> address := row*WIDTH, remaining := WIDTH, go to STREAM.
    - row >= HEIGHT -> err_count+1, stay IDLE.
  - cmd 0x03 SWAP -> swap_req:=1 next cycle, go to SWAP_WAIT.
  - cmd 0x04 BRIGHTNESS -> brightness := arg[7:0] next cycle, stay IDLE.
  - Any other cmd -> err_count+1, stay IDLE.
- STREAM:
  - Every word_valid is a pixel.
  - Next cycle: fb_we=1, fb_addr=current address, fb_data=word_data[23:0].
  - Address increments and remaining decrements after each write.
  - Bits [31:24] of pixel words are ignored; a 0xA5 pixel is not a header.
  - The word that brings remaining to 0 returns to IDLE on that same edge.
  - The next word after it is decoded as a header.
  - Address does not wrap within a frame; max written address is WIDTH*HEIGHT-1.
- Latency: exactly 1 cycle from word_valid to fb_we; fb_we never asserted without a preceding word_valid.
- SWAP_WAIT:
  - swap_req held at 1 until swap_ack=1 is sampled.
  - On that edge: swap_req:=0, fb_buf toggles, go to IDLE.
  - If swap_ack is already high on the first SWAP_WAIT cycle, the swap completes on that edge.
  - word_valid in SWAP_WAIT: word dropped, err_count+1.
  - word_valid and swap_ack in the same cycle: word dropped and counted, swap completes.
- err_count saturates at 255, never wraps; it clears only on reset.
- busy is a combinational decode of state != IDLE.

Test Plan:
- Reset, then START_FRAME (0xA5010000) followed by WIDTH*HEIGHT=2048 pixel words with data = index:
  - Expect 2048 fb_we pulses, fb_addr 0..2047, fb_data[23:0] = index[23:0], fb_buf=1.
  - busy returns to 0 after the last pixel.
- START_ROW row=5 (0xA5020005) plus 64 pixels:
  - Expect fb_addr 320..383.
  - A 65th word 0xA5040080 is decoded as a header: brightness=0x80, no fb_we.
- SWAP with swap_ack delayed 7 cycles:
  - Expect swap_req high for exactly those cycles and fb_buf 1->0 on the ack edge.
  - Send 2 words during the wait: err_count=2, no fb_we.
- Error cases: bad sync 0x12010000, START_ROW row=32, cmd 0x7F:
  - Expect err_count=3, state stays IDLE, no fb_we.
  - Then 300 bad words: err_count holds at 255.
- Reset asserted at pixel 10 of START_FRAME:
  - Expect fb_we=0 from the next cycle and all outputs at their reset values.
  - A fresh START_FRAME restarts at fb_addr=0.
- Back-to-back word_valid every cycle during STREAM:
  - Expect fb_we high continuously with fb_addr incrementing by 1 per cycle and no dropped pixels.
